// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the instruction size and the default reset vector.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_FLUSH    = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the external PC register, issues one
// instruction-memory read at a time and hands fetched words to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        misalign_err
);

  fetch_state_e state_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         misalign_err_q;
  logic [31:0]  pc_d;

  logic redirect;
  logic ack_ok;

  // IDLE ignores redirects; an ack only counts while a request is outstanding.
  assign redirect = branch_taken && (state_q != ST_IDLE);
  assign ack_ok   = imem_ack && imem_req_q;

  always_comb begin
    pc_d = pc_current;
    if (!reset || state_q == ST_IDLE)
      pc_d = RESET_VECTOR;
    else if (redirect)
      pc_d = word_align(branch_target);
    else if (state_q == ST_FETCH && ack_ok)
      pc_d = pc_current + 32'(INSTR_BYTES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= RESET_VECTOR;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= redirect && (branch_target[1:0] != 2'b00);
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;

        // First FETCH cycle latches the address; the request goes out the cycle after.
        ST_FETCH: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            if (ack_ok) begin
              imem_req_q <= 1'b0;
            end else if (imem_req_q) begin
              state_q <= ST_FLUSH;
            end
          end else if (!imem_req_q) begin
            imem_addr_q <= pc_current;
            imem_req_q  <= 1'b1;
          end else if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= imem_addr_q;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= ST_WAIT_DEC;
          end
        end

        ST_WAIT_DEC: begin
          if (redirect || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end

        // Drain the stale request; a redirect here only retargets the PC.
        ST_FLUSH: begin
          if (redirect) instr_valid_q <= 1'b0;
          if (ack_ok) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc_next      = pc_d;
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the PC register is modelled here as the
// sibling that loads pc_next every edge and feeds it back as pc_current.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current, pc_next;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pc_current <= pc_next;

  fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_current   (pc_current),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pcn;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        mis;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic br, input logic [31:0] tgt, input logic [31:0] pcn,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] ipc, input logic [31:0] ins, input logic mis);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.tgt = tgt; v.pcn = pcn;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ins = ins; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] ipc, input logic [31:0] ins,
                          input logic mis);
    chk({tag, ".req"},   32'(imem_req),     32'(req));
    chk({tag, ".addr"},  imem_addr,         addr);
    chk({tag, ".valid"}, 32'(instr_valid),  32'(vld));
    chk({tag, ".ipc"},   instr_pc,          ipc);
    chk({tag, ".instr"}, instr,             ins);
    chk({tag, ".mis"},   32'(misalign_err), 32'(mis));
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
    branch_taken = br; branch_target = tgt;
  endtask

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_0004, A2 = 32'h3333_0008;
  localparam logic [31:0] A3 = 32'h4444_000C, A4 = 32'h5555_0100, A5 = 32'h6666_0200;
  localparam logic [31:0] A6 = 32'h7777_FFFC, A7 = 32'h8888_0000, BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] TOP = 32'hFFFF_FFFC;

  initial begin
    //             ack rdata rdy br tgt        | pcn       req addr      vld ipc       ins mis
    tbl[0]  = mk(0, 0,   0, 0, 0,             RV,        0, RV,        0, 0,        0,  0);
    tbl[1]  = mk(0, 0,   0, 0, 0,             0,         1, 0,         0, 0,        0,  0);
    tbl[2]  = mk(1, A0,  1, 0, 0,             4,         0, 0,         1, 0,        A0, 0);
    tbl[3]  = mk(0, 0,   1, 0, 0,             4,         0, 0,         0, 0,        A0, 0);
    tbl[4]  = mk(0, 0,   1, 0, 0,             4,         1, 4,         0, 0,        A0, 0);
    tbl[5]  = mk(1, A1,  1, 0, 0,             8,         0, 4,         1, 4,        A1, 0);
    tbl[6]  = mk(0, 0,   1, 0, 0,             8,         0, 4,         0, 4,        A1, 0);
    tbl[7]  = mk(0, 0,   1, 0, 0,             8,         1, 8,         0, 4,        A1, 0);
    tbl[8]  = mk(1, A2,  0, 0, 0,             32'hC,     0, 8,         1, 8,        A2, 0);
    tbl[9]  = mk(0, 0,   0, 0, 0,             32'hC,     0, 8,         1, 8,        A2, 0);
    tbl[10] = mk(0, 0,   1, 0, 0,             32'hC,     0, 8,         0, 8,        A2, 0);
    tbl[11] = mk(0, 0,   0, 0, 0,             32'hC,     1, 32'hC,     0, 8,        A2, 0);
    tbl[12] = mk(0, 0,   0, 0, 0,             32'hC,     1, 32'hC,     0, 8,        A2, 0);
    tbl[13] = mk(0, 0,   0, 0, 0,             32'hC,     1, 32'hC,     0, 8,        A2, 0);
    tbl[14] = mk(0, 0,   0, 0, 0,             32'hC,     1, 32'hC,     0, 8,        A2, 0);
    tbl[15] = mk(1, A3,  0, 0, 0,             32'h10,    0, 32'hC,     1, 32'hC,    A3, 0);
    tbl[16] = mk(0, 0,   1, 0, 0,             32'h10,    0, 32'hC,     0, 32'hC,    A3, 0);
    tbl[17] = mk(0, 0,   0, 0, 0,             32'h10,    1, 32'h10,    0, 32'hC,    A3, 0);
    tbl[18] = mk(0, 0,   0, 1, 32'h100,       32'h100,   1, 32'h10,    0, 32'hC,    A3, 0);
    tbl[19] = mk(0, 0,   0, 0, 0,             32'h100,   1, 32'h10,    0, 32'hC,    A3, 0);
    tbl[20] = mk(1, BAD, 1, 0, 0,             32'h100,   0, 32'h10,    0, 32'hC,    A3, 0);
    tbl[21] = mk(0, 0,   0, 0, 0,             32'h100,   1, 32'h100,   0, 32'hC,    A3, 0);
    tbl[22] = mk(1, A4,  0, 0, 0,             32'h104,   0, 32'h100,   1, 32'h100,  A4, 0);
    tbl[23] = mk(0, 0,   1, 1, 32'h203,       32'h200,   0, 32'h100,   0, 32'h100,  A4, 1);
    tbl[24] = mk(0, 0,   0, 0, 0,             32'h200,   1, 32'h200,   0, 32'h100,  A4, 0);
    tbl[25] = mk(1, A5,  0, 0, 0,             32'h204,   0, 32'h200,   1, 32'h200,  A5, 0);
    tbl[26] = mk(0, 0,   0, 1, TOP,           TOP,       0, 32'h200,   0, 32'h200,  A5, 0);
    tbl[27] = mk(0, 0,   0, 0, 0,             TOP,       1, TOP,       0, 32'h200,  A5, 0);
    tbl[28] = mk(1, A6,  0, 0, 0,             0,         0, TOP,       1, TOP,      A6, 0);
    tbl[29] = mk(0, 0,   1, 0, 0,             0,         0, TOP,       0, TOP,      A6, 0);
    tbl[30] = mk(0, 0,   0, 0, 0,             0,         1, 0,         0, TOP,      A6, 0);
    tbl[31] = mk(0, 0,   0, 1, 32'h40,        32'h40,    1, 0,         0, TOP,      A6, 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_regs("reset", 0, RV, 0, 0, 0, 0);
    chk("reset.pcn", pc_next, RV);

    reset = 1'b1;
    #1;
    chk("idle.pcn", pc_next, RV);
    chk("idle.req", 32'(imem_req), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      #1;
      chk($sformatf("row%0d.pcn", i), pc_next, tbl[i].pcn);
      @(posedge clk);
      #1;
      chk_regs($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
               tbl[i].ipc, tbl[i].ins, tbl[i].mis);
    end

    // Now in FLUSH with a request outstanding: reset mid-cycle, without an ack.
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_regs("rstflush", 0, RV, 0, 0, 0, 0);
    chk("rstflush.pcn", pc_next, RV);
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("rsthold", 0, RV, 0, 0, 0, 0);
    imem_ack = 1'b0;

    reset = 1'b1;
    #1;
    chk("rel.idle.pcn", pc_next, RV);
    @(posedge clk);
    #1;
    chk("rel.entry.req", 32'(imem_req), 32'd0);
    chk("rel.entry.pcn", pc_next, RV);
    @(posedge clk);
    #1;
    chk("rel.req", 32'(imem_req), 32'd1);
    chk("rel.addr", imem_addr, RV);
    drive(1, A7, 0, 0, 0);
    #1;
    chk("rel.ack.pcn", pc_next, RV + 32'd4);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    chk_regs("rel.data", 0, RV, 1, RV, A7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR SHALL default to 32'h0000_0000 and give the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc_current  input  32  PC value currently held by the program_counter register.
REQ-005 pc_next  output  32  value loaded into the program_counter register on every clk edge.
REQ-006 imem_req  output  1  instruction-memory read request, held high until acknowledged.
REQ-007 imem_addr  output  32  registered fetch address, stable while imem_req=1.
REQ-008 imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  instr/instr_pc hold a fetched instruction for decode.
REQ-011 instr  output  32  registered instruction word.
REQ-012 instr_pc  output  32  address the instruction was fetched from.
REQ-013 instr_ready  input  1  decode accepts instr when instr_valid=1 and instr_ready=1.
REQ-014 branch_taken  input  1  one-cycle redirect strobe from execute.
REQ-015 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-016 misalign_err  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT_DEC and FLUSH.
REQ-018 IDLE: pc_next=RESET_VECTOR; next state FETCH unconditionally.
REQ-019 FETCH entry SHALL latch imem_addr=pc_current; imem_req=1 throughout FETCH.
REQ-020 FETCH with imem_ack=1 and no branch: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc_next=pc_current+4, next state WAIT_DEC.
REQ-021 FETCH without imem_ack: pc_next=pc_current; stay in FETCH; imem_addr unchanged.
REQ-022 WAIT_DEC: imem_req=0, pc_next=pc_current; on instr_ready=1, instr_valid<=0 and next state FETCH.
REQ-023 PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).
REQ-024 branch_taken=1 SHALL have priority over every other event in every state except IDLE.
REQ-025 On a redirect, pc_next={branch_target[31:2],2'b00} and instr_valid<=0 in the same edge; instr_ready in that cycle is ignored.
REQ-026 Redirect in WAIT_DEC, or in FETCH with imem_ack=1: rdata is discarded and next state is FETCH.
REQ-027 Redirect in FETCH with imem_ack=0: next state FLUSH.
REQ-028 FLUSH: imem_req=1 with the old imem_addr until imem_ack; data discarded; pc_next=pc_current; next state FETCH.
REQ-029 Redirect in FLUSH: pc_next takes the new target; state stays FLUSH.
REQ-030 misalign_err SHALL pulse for one cycle in the cycle after any accepted redirect with branch_target[1:0]!=0.
REQ-031 Fetch latency SHALL be 1 cycle from FETCH entry to imem_req, plus memory wait; at most one outstanding request.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, misalign_err=0.
REQ-033 pc_next SHALL equal RESET_VECTOR while in reset.
REQ-034 Reset asserted mid-request SHALL abandon the request without waiting for imem_ack.
REQ-035 Reset release SHALL be followed by one IDLE cycle, then FETCH at RESET_VECTOR.

Structure
REQ-036 The shared package fetch_pkg SHALL hold the FSM state enum, INSTR_BYTES=4 and the default RESET_VECTOR.
REQ-037 No sub-module SHALL be used.
REQ-038 The program_counter register SHALL be a sibling instance at the integration level, connected pc_next->nextInstruction and currentInstruction->pc_current.

Verification
REQ-039 Release reset, ack every request on its first cycle, hold instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, with one accepted instruction per 3 cycles.
REQ-040 In FETCH with imem_ack withheld for 3 cycles -> imem_addr is stable for 4 cycles and pc_current is unchanged.
REQ-041 Redirect to 0x100 in FETCH with no ack, ack after 2 cycles -> the old word is never presented and the next imem_addr is 0x100.
REQ-042 Redirect to 0x203 in WAIT_DEC while instr_ready=1 -> instr_valid drops, the next fetch is 0x200 and misalign_err pulses once.
REQ-043 pc_current=0xFFFF_FFFC, ack -> pc_next=0x0.
REQ-044 Assert reset during FLUSH -> all outputs are at reset values immediately, and the first fetch after release is at RESET_VECTOR.
